// File: rtl/bus_pkg.sv
// Shared definitions for the datapath bus: default sizing and the CPU
// source map that fixes which index each bus source occupies.
package bus_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_NSRC   = 24;
  localparam int DEF_CNT_W  = 8;

  // CPU source map (index into src_data / src_out)
  localparam int SRC_R0     = 0;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_RA     = 23;

endpackage

// File: rtl/bus_prio_enc.sv
// Combinational highest-index priority encoder. It reports the winning index,
// whether any request is present, and whether two or more requests are present.
module bus_prio_enc #(
  parameter int N     = 24,
  parameter int IDX_W = $clog2(N)
)(
  input  logic [N-1:0]     i_req,
  output logic [IDX_W-1:0] o_index,
  output logic             o_any,
  output logic             o_multi
);

  // Scan upward so that later (higher) indices overwrite lower ones; a request
  // seen while one is already pending marks multiple drivers.
  always_comb begin
    o_index = '0;
    o_any   = 1'b0;
    o_multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_req[i]) begin
        if (o_any) o_multi = 1'b1;
        o_any   = 1'b1;
        o_index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_mux_reg.sv
// Registered datapath bus multiplexer with bus keeper and contention reporting.
// Enables sampled on edge n are reflected on every output after edge n; all
// outputs come straight from flops.
module bus_mux_reg
  import bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NSRC  = DEF_NSRC,
  parameter int CNT_W = DEF_CNT_W,
  parameter int SEL_W = $clog2(NSRC)
)(
  input  logic                    clk,
  input  logic                    clr,
  input  logic [NSRC*WIDTH-1:0]   src_data,
  input  logic [NSRC-1:0]         src_out,
  input  logic                    err_clr,
  output logic [WIDTH-1:0]        bus_out,
  output logic                    bus_valid,
  output logic [SEL_W-1:0]        bus_src,
  output logic                    contention,
  output logic                    err_sticky,
  output logic [CNT_W-1:0]        err_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] w_words [NSRC];
  logic [SEL_W-1:0] w_idx;
  logic             w_any;
  logic             w_multi;
  logic [WIDTH-1:0] w_sel_word;

  logic [WIDTH-1:0] r_bus;
  logic             r_valid;
  logic [SEL_W-1:0] r_src;
  logic             r_cont;
  logic             r_sticky;
  logic [CNT_W-1:0] r_count;

  for (genvar g = 0; g < NSRC; g++) begin : g_unpack
    assign w_words[g] = src_data[g*WIDTH +: WIDTH];
  end

  bus_prio_enc #(
    .N     (NSRC),
    .IDX_W (SEL_W)
  ) u_prio_enc (
    .i_req   (src_out),
    .o_index (w_idx),
    .o_any   (w_any),
    .o_multi (w_multi)
  );

  assign w_sel_word = w_words[w_idx];

  // Bus register and keeper: load the winner when anyone drives, otherwise hold.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_bus   <= '0;
      r_src   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_any;
      if (w_any) begin
        r_bus <= w_sel_word;
        r_src <= w_idx;
      end
    end
  end

  // Contention pulse, sticky flag and saturating counter; a contention cycle
  // beats a simultaneous err_clr and restarts the count at one.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cont   <= 1'b0;
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else begin
      r_cont <= w_multi;
      if (w_multi) begin
        r_sticky <= 1'b1;
        if (err_clr)
          r_count <= CNT_W'(1);
        else if (r_count != CNT_MAX)
          r_count <= r_count + CNT_W'(1);
      end else if (err_clr) begin
        r_sticky <= 1'b0;
        r_count  <= '0;
      end
    end
  end

  assign bus_out    = r_bus;
  assign bus_valid  = r_valid;
  assign bus_src    = r_src;
  assign contention = r_cont;
  assign err_sticky = r_sticky;
  assign err_count  = r_count;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Bench for bus_mux_reg: directed scenarios plus randomized traffic, checked
// against a transaction-level reference model. A second instance with a 2-bit
// counter shares the stimulus to exercise saturation.
module tb_bus_mux_reg;
  import bus_pkg::*;

  localparam int WIDTH = 32;
  localparam int NSRC  = 24;
  localparam int SEL_W = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic [NSRC*WIDTH-1:0] src_data = '0;
  logic [NSRC-1:0]       src_out  = '0;
  logic                  err_clr  = 1'b0;

  logic [WIDTH-1:0] bus_out,   b2_bus_out;
  logic             bus_valid, b2_bus_valid;
  logic [SEL_W-1:0] bus_src,   b2_bus_src;
  logic             contention, b2_contention;
  logic             err_sticky, b2_err_sticky;
  logic [7:0]       err_count;
  logic [1:0]       b2_err_count;

  bus_mux_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .err_clr(err_clr),
    .bus_out(bus_out), .bus_valid(bus_valid), .bus_src(bus_src),
    .contention(contention), .err_sticky(err_sticky), .err_count(err_count)
  );

  bus_mux_reg #(.WIDTH(WIDTH), .NSRC(NSRC), .CNT_W(2)) dut2 (
    .clk(clk), .clr(clr), .src_data(src_data), .src_out(src_out), .err_clr(err_clr),
    .bus_out(b2_bus_out), .bus_valid(b2_bus_valid), .bus_src(b2_bus_src),
    .contention(b2_contention), .err_sticky(b2_err_sticky), .err_count(b2_err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_bus;
  logic             m_valid;
  logic [SEL_W-1:0] m_src;
  logic             m_cont;
  logic             m_sticky;
  int               m_cnt8;
  int               m_cnt2;

  logic [WIDTH-1:0] exp_q[$];

  task automatic model_reset();
    m_bus = '0; m_valid = 1'b0; m_src = '0; m_cont = 1'b0;
    m_sticky = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  // One clock edge of the bus, described by its rules rather than its registers.
  task automatic model_edge();
    int drivers;
    int win;
    if (!clr) begin
      model_reset();
      return;
    end
    drivers = $countones(src_out);
    win = -1;
    for (int i = NSRC - 1; i >= 0; i--)
      if (src_out[i] && win < 0) win = i;
    if (win >= 0) begin
      m_bus   = src_data[win*WIDTH +: WIDTH];
      m_src   = SEL_W'(win);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    m_cont = (drivers >= 2);
    if (drivers >= 2) begin
      m_sticky = 1'b1;
      m_cnt8 = err_clr ? 1 : ((m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1);
      m_cnt2 = err_clr ? 1 : ((m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1);
    end else if (err_clr) begin
      m_sticky = 1'b0;
      m_cnt8 = 0;
      m_cnt2 = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_word(input int idx, input logic [WIDTH-1:0] w);
    src_data[idx*WIDTH +: WIDTH] = w;
  endtask

  task automatic randomize_words();
    for (int i = 0; i < NSRC; i++) set_word(i, WIDTH'($urandom));
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    randomize_words();
    src_out = NSRC'($urandom);
    clr = 1'b1;
    repeat (3) step();
    src_out = (NSRC'(1) << 7) | (NSRC'(1) << 9);
    step();
    #2 clr = 1'b0;
    #1;
    model_reset();
    n_checks++; if (bus_out !== '0)      begin n_fail++; $display("FAIL reset_bus_out got=%h exp=0", bus_out); end
    n_checks++; if (bus_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_bus_valid got=%b exp=0", bus_valid); end
    n_checks++; if (bus_src !== '0)      begin n_fail++; $display("FAIL reset_bus_src got=%0d exp=0", bus_src); end
    n_checks++; if (contention !== 1'b0) begin n_fail++; $display("FAIL reset_contention got=%b exp=0", contention); end
    n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err_sticky got=%b exp=0", err_sticky); end
    n_checks++; if (err_count !== '0)    begin n_fail++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    n_checks++; if (b2_err_count !== '0 || b2_err_sticky !== 1'b0)
      begin n_fail++; $display("FAIL reset_dut2_err got=%0d/%b exp=0/0", b2_err_count, b2_err_sticky); end
    src_out = '0;
    #1 clr = 1'b1;
  endtask

  task automatic test_single_driver();
    set_word(5, 32'hDEADBEEF);
    src_out = NSRC'(1) << 5;
    step();
    n_checks++; if (bus_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_bus_out got=%h exp=deadbeef", bus_out); end
    n_checks++; if (bus_src !== 5'd5)         begin n_fail++; $display("FAIL single_bus_src got=%0d exp=5", bus_src); end
    n_checks++; if (bus_valid !== 1'b1)       begin n_fail++; $display("FAIL single_bus_valid got=%b exp=1", bus_valid); end
    n_checks++; if (contention !== 1'b0)      begin n_fail++; $display("FAIL single_contention got=%b exp=0", contention); end
  endtask

  task automatic test_keeper();
    src_out = '0;
    for (int k = 0; k < 3; k++) begin
      set_word(5, WIDTH'($urandom));
      step();
      n_checks++; if (bus_out !== 32'hDEADBEEF) begin n_fail++; $display("FAIL keeper_bus_out cyc=%0d got=%h exp=deadbeef", k, bus_out); end
      n_checks++; if (bus_valid !== 1'b0)       begin n_fail++; $display("FAIL keeper_bus_valid cyc=%0d got=%b exp=0", k, bus_valid); end
      n_checks++; if (bus_src !== 5'd5)         begin n_fail++; $display("FAIL keeper_bus_src cyc=%0d got=%0d exp=5", k, bus_src); end
    end
  endtask

  task automatic test_contention();
    set_word(SRC_PC, 32'h00000100);
    set_word(3, 32'h33333333);
    src_out = (NSRC'(1) << 3) | (NSRC'(1) << SRC_PC);
    step();
    src_out = '0;
    n_checks++; if (bus_out !== 32'h00000100) begin n_fail++; $display("FAIL cont_bus_out got=%h exp=00000100", bus_out); end
    n_checks++; if (bus_src !== 5'd20)        begin n_fail++; $display("FAIL cont_bus_src got=%0d exp=20", bus_src); end
    n_checks++; if (contention !== 1'b1)      begin n_fail++; $display("FAIL cont_pulse got=%b exp=1", contention); end
    n_checks++; if (err_sticky !== 1'b1)      begin n_fail++; $display("FAIL cont_sticky got=%b exp=1", err_sticky); end
    n_checks++; if (err_count !== 8'd1)       begin n_fail++; $display("FAIL cont_count got=%0d exp=1", err_count); end
    step();
    n_checks++; if (contention !== 1'b0)      begin n_fail++; $display("FAIL cont_pulse_end got=%b exp=0", contention); end
    n_checks++; if (err_sticky !== 1'b1 || err_count !== 8'd1)
      begin n_fail++; $display("FAIL cont_hold got=%b/%0d exp=1/1", err_sticky, err_count); end
  endtask

  task automatic test_saturation_clear();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      src_out = (NSRC'(1) << $urandom_range(0, 11)) | (NSRC'(1) << $urandom_range(12, 23));
      step();
      n_checks++; if (b2_err_count !== 2'((k > 3) ? 3 : k))
        begin n_fail++; $display("FAIL sat_count2 k=%0d got=%0d exp=%0d", k, b2_err_count, (k > 3) ? 3 : k); end
      n_checks++; if (err_count !== 8'(k))
        begin n_fail++; $display("FAIL sat_count8 k=%0d got=%0d exp=%0d", k, err_count, k); end
    end
    src_out = '0;
    step();
    n_checks++; if (b2_err_count !== 2'd3) begin n_fail++; $display("FAIL sat_held got=%0d exp=3", b2_err_count); end
    err_clr = 1'b1;
    step();
    n_checks++; if (b2_err_sticky !== 1'b0 || b2_err_count !== 2'd0 || err_count !== 8'd0)
      begin n_fail++; $display("FAIL clr_alone got=%b/%0d/%0d exp=0/0/0", b2_err_sticky, b2_err_count, err_count); end
    n_checks++; if (bus_out !== m_bus || bus_src !== m_src)
      begin n_fail++; $display("FAIL clr_bus_untouched got=%h/%0d exp=%h/%0d", bus_out, bus_src, m_bus, m_src); end
    src_out = (NSRC'(1) << 1) | (NSRC'(1) << 2);
    step();
    err_clr = 1'b0;
    src_out = '0;
    n_checks++; if (b2_err_sticky !== 1'b1 || b2_err_count !== 2'd1 || err_count !== 8'd1)
      begin n_fail++; $display("FAIL clr_with_cont got=%b/%0d/%0d exp=1/1/1", b2_err_sticky, b2_err_count, err_count); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp_w;
    randomize_words();
    for (int k = 0; k < 6; k++) begin
      src_out = NSRC'(1) << k;
      exp_q.push_back(src_data[k*WIDTH +: WIDTH]);
      if (k == 4) begin
        #2 clr = 1'b0;
        #1;
        model_reset();
        n_checks++; if (bus_out !== '0 || bus_valid !== 1'b0 || bus_src !== '0)
          begin n_fail++; $display("FAIL b2b_midreset got=%h/%b/%0d exp=0/0/0", bus_out, bus_valid, bus_src); end
        #1 clr = 1'b1;
      end
      step();
      exp_w = exp_q.pop_front();
      n_checks++; if (bus_out !== exp_w || bus_src !== SEL_W'(k) || bus_valid !== 1'b1)
        begin n_fail++; $display("FAIL b2b_seq k=%0d got=%h/%0d/%b exp=%h/%0d/1", k, bus_out, bus_src, bus_valid, exp_w, k); end
    end
    src_out = '0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0:       src_out = '0;
        1:       src_out = NSRC'(1) << $urandom_range(0, NSRC - 1);
        2:       src_out = (NSRC'(1) << $urandom_range(0, NSRC - 1)) | (NSRC'(1) << $urandom_range(0, NSRC - 1));
        default: src_out = NSRC'($urandom);
      endcase
      err_clr = ($urandom_range(0, 9) == 0);
      for (int j = 0; j < 3; j++) set_word($urandom_range(0, NSRC - 1), WIDTH'($urandom));
      step();
      n_checks++;
      if (bus_out !== m_bus || bus_valid !== m_valid || bus_src !== m_src || contention !== m_cont ||
          err_sticky !== m_sticky || err_count !== 8'(m_cnt8) || b2_err_count !== 2'(m_cnt2)) begin
        n_fail++;
        $display("FAIL random k=%0d got=%h/%b/%0d/%b/%b/%0d/%0d exp=%h/%b/%0d/%b/%b/%0d/%0d", k,
                 bus_out, bus_valid, bus_src, contention, err_sticky, err_count, b2_err_count,
                 m_bus, m_valid, m_src, m_cont, m_sticky, m_cnt8, m_cnt2);
      end
    end
    err_clr = 1'b0;
    src_out = '0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    #12;
    test_reset();
    test_single_driver();
    test_keeper();
    test_contention();
    test_saturation_clear();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_mux_reg.md
# bus_mux_reg

Parametrised, registered successor to the datapath bus multiplexer. It selects one of NSRC source words onto a WIDTH-bit bus using one-hot "out" enables and registers the result, so the bus is stable for a full cycle. When no source drives, it holds the last value as a bus keeper. It detects multi-driver contention and reports it through a pulse, a sticky flag and a saturating counter. It sits between the register file, special registers (PC, HI, LO, Z, MDR, in-port) and every bus consumer in the CPU datapath.

## Interface
Parameters:
- WIDTH, 32, bus and source word width
- NSRC, 24, number of bus sources (min 2)
- CNT_W, 8, width of contention counter
- SEL_W, $clog2(NSRC), derived; width of source index

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous, active-low
- src_data  in  NSRC*WIDTH  flattened source words; source i at bits [i*WIDTH +: WIDTH]
- src_out  in  NSRC  per-source drive enables, nominally one-hot or zero
- err_clr  in  1  synchronous clear of err_sticky and err_count
- bus_out  out  WIDTH  registered bus value
- bus_valid  out  1  a source drove bus_out in the previous cycle
- bus_src  out  SEL_W  index of the source that last drove the bus
- contention  out  1  one-cycle pulse: more than one enable was high in the previous cycle
- err_sticky  out  1  contention has occurred since reset or err_clr
- err_count  out  CNT_W  saturating count of contention cycles

## Operation
- Winner: highest-index asserted bit of src_out. This is fixed priority, so a higher index always beats a lower index.
- Any enable high: on the clock edge, bus_out <= src_data[winner], bus_src <= winner, bus_valid <= 1.
- No enable high: bus_out and bus_src hold their values, and bus_valid <= 0. This is keeper behaviour; the bus never returns to X or 0.
- Contention (popcount(src_out) >= 2):
  - The winner still drives.
  - contention <= 1 for one cycle.
  - err_sticky <= 1.
  - err_count <= err_count + 1, saturating at 2^CNT_W - 1. There is no wrap-around.
- No contention: contention <= 0.
- err_clr alone: err_sticky <= 0 and err_count <= 0. It has no effect on bus_out, bus_valid, bus_src or contention.
- err_clr together with contention in the same cycle: contention takes precedence. err_sticky <= 1 and err_count <= 1.
- Reset (clr low, at any time including mid-transfer): immediately and asynchronously, every output goes to 0. This covers bus_out, bus_valid, bus_src, contention, err_sticky and err_count.
- Reset release: normal operation resumes on the first rising edge with clr high.
- Enable bits at or above NSRC do not exist. NSRC is the exact source count.

## Timing
- Latency: 1 cycle. Enables and data sampled at edge n appear on bus_out after edge n.
- A consumer latches bus_out on edge n+1 for a transfer requested in cycle n. The control unit asserts Xout in cycle n and Yin in cycle n+1.
- contention, err_sticky and err_count update on the same edge as bus_out.
- All outputs are driven directly from flops; there is no combinational path from input to output.
- Back-to-back transfers are supported, so a new source can be selected every cycle.

## Structure
- Shared package bus_pkg:
  - localparam source indices for the CPU map: R0..R15 = 0..15, HI = 16, LO = 17, ZHI = 18, ZLO = 19, PC = 20, MDR = 21, INPORT = 22, RA = 23.
  - Default WIDTH and NSRC values.
- Sub-module bus_prio_enc: a combinational highest-index priority encoder, parametrised by N.
  - Outputs: index, any, multi (popcount >= 2).
  - bus_mux_reg instantiates one and contains the registers, keeper and error logic.

## Test plan
- Reset: drive clr low with random inputs → all outputs 0 asynchronously, without waiting for a clock edge.
- Single driver: src_data[5] = 32'hDEADBEEF, src_out = 1<<5 for one cycle → next cycle bus_out = DEADBEEF, bus_src = 5, bus_valid = 1, contention = 0.
- Keeper: after the single-driver case, src_out = 0 for 3 cycles → bus_out stays DEADBEEF, bus_valid = 0, bus_src = 5.
- Contention and priority: src_out bits 3 and 20 high, src_data[20] = 32'h00000100 → bus_out = 00000100, bus_src = 20, contention pulses for 1 cycle, err_sticky = 1, err_count = 1.
- Saturation and clear: CNT_W = 2 with 5 contention cycles → err_count = 3 and held. Then err_clr with no contention → err_sticky = 0, err_count = 0. Then err_clr together with contention → err_sticky = 1, err_count = 1.
- Back-to-back and reset mid-operation: sources 0, 1, 2 on consecutive cycles → bus_out sequence follows with 1-cycle lag. Pulse clr low mid-sequence → outputs 0 at once, and the first post-reset transfer is correct.
